// File: rtl/codec_bringup_seq.sv
// Audio codec power-up sequencer: power-down hold, settle, I2C register init with bounded
// retries, then datapath enable with a muted warm-up before going live.
module codec_bringup_seq #(
  parameter int unsigned FS_DIV             = 256,
  parameter int unsigned PDN_LOW_FRAMES     = 4,
  parameter int unsigned SETTLE_FRAMES      = 48,
  parameter int unsigned I2C_TIMEOUT_FRAMES = 1024,
  parameter int unsigned MUTE_FRAMES        = 64,
  parameter int unsigned MAX_RETRY          = 3
) (
  input  logic       clk_256fs,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       i2c_done,
  input  logic       i2c_err,
  output logic       codec_pdn_n,
  output logic       i2c_start,
  output logic       audio_en,
  output logic       mute,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned MaxA      = (PDN_LOW_FRAMES > SETTLE_FRAMES) ?
                                      PDN_LOW_FRAMES : SETTLE_FRAMES;
  localparam int unsigned MaxB      = (I2C_TIMEOUT_FRAMES > MUTE_FRAMES) ?
                                      I2C_TIMEOUT_FRAMES : MUTE_FRAMES;
  localparam int unsigned MaxFrames = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxCycles = MaxFrames * FS_DIV;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] HoldLoad    = TimerW'(PDN_LOW_FRAMES * FS_DIV - 1);
  localparam logic [TimerW-1:0] SettleLoad  = TimerW'(SETTLE_FRAMES * FS_DIV - 1);
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(I2C_TIMEOUT_FRAMES * FS_DIV - 1);
  localparam logic [TimerW-1:0] MuteLoad    = TimerW'(MUTE_FRAMES * FS_DIV - 1);
  localparam logic [1:0]        MaxRetry    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StSettle   = 3'd1,
    StI2cStart = 3'd2,
    StI2cWait  = 3'd3,
    StUnmute   = 3'd4,
    StRun      = 3'd5,
    StFault    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [1:0]          retry_q, retry_d;
  logic                fail;
  logic                timer_zero;

  function automatic logic [TimerW-1:0] load_for(state_e s);
    case (s)
      StHold:    load_for = HoldLoad;
      StSettle:  load_for = SettleLoad;
      StI2cWait: load_for = TimeoutLoad;
      StUnmute:  load_for = MuteLoad;
      default:   load_for = '0;
    endcase
  endfunction

  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      StHold:     if (timer_zero) state_d = StSettle;
      StSettle:   if (timer_zero) state_d = StI2cStart;
      StI2cStart: state_d = StI2cWait;
      StI2cWait: begin
        // A completion on the timeout cycle is judged on its error flag, not as a timeout.
        if (i2c_done) begin
          if (i2c_err) fail = 1'b1;
          else         state_d = StUnmute;
        end else if (timer_zero) begin
          fail = 1'b1;
        end
      end
      StUnmute:   if (timer_zero) state_d = StRun;
      StRun, StFault: state_d = state_q;
      default:    state_d = StHold;
    endcase

    if (fail) begin
      if (retry_q < MaxRetry) begin
        retry_d = retry_q + 2'd1;
        state_d = StHold;
      end else begin
        state_d = StFault;
      end
    end

    if (restart) begin
      state_d = StHold;
      retry_d = '0;
    end

    if (restart || (state_d != state_q)) begin
      timer_d = load_for(state_d);
    end else if (!timer_zero) begin
      timer_d = timer_q - TimerW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      timer_q     <= HoldLoad;
      retry_q     <= '0;
      codec_pdn_n <= 1'b0;
      i2c_start   <= 1'b0;
      audio_en    <= 1'b0;
      mute        <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      codec_pdn_n <= state_d inside {StSettle, StI2cStart, StI2cWait, StUnmute, StRun};
      i2c_start   <= (state_d == StI2cStart);
      audio_en    <= state_d inside {StUnmute, StRun};
      mute        <= (state_d != StRun);
      ready       <= (state_d == StRun);
      fault       <= (state_d == StFault);
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_codec_bringup_seq.sv
// Self-checking bench for codec_bringup_seq: expected output snapshots are queued per cycle
// when stimulus is planned and compared as the clock reaches each cycle.
module tb_codec_bringup_seq;

  localparam logic [2:0] Hold = 3'd0, Settle = 3'd1, Start = 3'd2, Wait = 3'd3;
  localparam logic [2:0] Unmute = 3'd4, Run = 3'd5, Fault = 3'd6;

  logic       clk_256fs = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       i2c_done = 1'b0;
  logic       i2c_err = 1'b0;
  logic       codec_pdn_n, i2c_start, audio_en, mute, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  logic [10:0] obs;

  typedef struct {
    int          cyc;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  codec_bringup_seq #(
    .FS_DIV             (4),
    .PDN_LOW_FRAMES     (2),
    .SETTLE_FRAMES      (3),
    .I2C_TIMEOUT_FRAMES (5),
    .MUTE_FRAMES        (2),
    .MAX_RETRY          (2)
  ) dut (
    .clk_256fs   (clk_256fs),
    .rst_n       (rst_n),
    .restart     (restart),
    .i2c_done    (i2c_done),
    .i2c_err     (i2c_err),
    .codec_pdn_n (codec_pdn_n),
    .i2c_start   (i2c_start),
    .audio_en    (audio_en),
    .mute        (mute),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  always #5 clk_256fs = ~clk_256fs;

  assign obs = {state, retry_cnt, codec_pdn_n, i2c_start, audio_en, mute, ready, fault};

  // {state, retry_cnt, pdn_n, i2c_start, audio_en, mute, ready, fault} for a given state.
  function automatic logic [10:0] exp_out(logic [2:0] st, logic [1:0] rc);
    logic pdn, stt, en, mt, rdy, flt;
    pdn = (st == Settle) || (st == Start) || (st == Wait) || (st == Unmute) || (st == Run);
    stt = (st == Start);
    en  = (st == Unmute) || (st == Run);
    mt  = (st != Run);
    rdy = (st == Run);
    flt = (st == Fault);
    return {st, rc, pdn, stt, en, mt, rdy, flt};
  endfunction

  function automatic void push(int c, logic [2:0] st, logic [1:0] rc);
    exp_t e;
    e.cyc = c;
    e.val = exp_out(st, rc);
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk_256fs);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== exp_out(Hold, 2'd0)) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", obs, exp_out(Hold, 2'd0));
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_normal();
    int   b;
    exp_t e;
    b = cyc;
    push(b + 7, Hold, 0);    push(b + 8, Settle, 0);  push(b + 19, Settle, 0);
    push(b + 20, Start, 0);  push(b + 21, Wait, 0);   push(b + 30, Wait, 0);
    push(b + 31, Unmute, 0); push(b + 38, Unmute, 0); push(b + 39, Run, 0);
    push(b + 42, Run, 0);
    while (cyc < b + 43) begin
      i2c_done = (cyc == b + 30);
      i2c_err  = 1'b0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL normal cyc=%0d got=%b exp=%b", e.cyc, obs, e.val);
        end
      end
    end
    i2c_done = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL normal pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_i2c_retry();
    int   b;
    exp_t e;
    b = cyc + 1;
    push(b, Hold, 0);        push(b + 30, Wait, 0);   push(b + 31, Hold, 1);
    push(b + 38, Hold, 1);   push(b + 39, Settle, 1); push(b + 50, Settle, 1);
    push(b + 51, Start, 1);  push(b + 52, Wait, 1);   push(b + 61, Unmute, 1);
    push(b + 69, Run, 1);
    while (cyc < b + 74) begin
      restart  = (cyc == b - 1);
      i2c_done = (cyc == b + 30) || (cyc == b + 60);
      i2c_err  = (cyc == b + 30);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL i2c_retry cyc=%0d got=%b exp=%b", e.cyc - b, obs, e.val);
        end
      end
    end
    restart = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL i2c_retry pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int   b;
    exp_t e;
    b = cyc + 1;
    push(b, Hold, 0);        push(b + 21, Wait, 0);    push(b + 40, Wait, 0);
    push(b + 41, Hold, 1);   push(b + 62, Wait, 1);    push(b + 81, Wait, 1);
    push(b + 82, Hold, 2);   push(b + 103, Wait, 2);   push(b + 122, Wait, 2);
    push(b + 123, Fault, 2); push(b + 600, Fault, 2);  push(b + 1122, Fault, 2);
    while (cyc < b + 1124) begin
      restart = (cyc == b - 1);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL timeout cyc=%0d got=%b exp=%b", e.cyc - b, obs, e.val);
        end
      end
    end
    restart = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart();
    int   b, b2, b3;
    exp_t e;
    b  = cyc + 1;
    b2 = b + 56;
    b3 = b2 + 26;
    push(b, Hold, 0);         push(b + 31, Hold, 1);    push(b + 52, Wait, 1);
    push(b + 55, Wait, 1);    push(b2, Hold, 0);        push(b2 + 7, Hold, 0);
    push(b2 + 8, Settle, 0);  push(b2 + 20, Start, 0);  push(b2 + 25, Wait, 0);
    push(b3, Hold, 0);        push(b3 + 7, Hold, 0);    push(b3 + 8, Settle, 0);
    push(b3 + 20, Start, 0);  push(b3 + 30, Wait, 0);   push(b3 + 31, Unmute, 0);
    push(b3 + 39, Run, 0);
    while (cyc < b3 + 40) begin
      restart  = (cyc == b - 1) || (cyc == b + 55) || (cyc == b2 + 25);
      i2c_done = (cyc == b + 30) || (cyc == b2 + 25) || (cyc == b3 + 30);
      i2c_err  = (cyc == b + 30);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL restart cyc=%0d got=%b exp=%b", e.cyc - b, obs, e.val);
        end
      end
    end
    restart = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL restart pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_boundary();
    int   b;
    exp_t e;
    b = cyc + 1;
    push(b, Hold, 0);         push(b + 11, Settle, 0);  push(b + 20, Start, 0);
    push(b + 40, Wait, 0);    push(b + 41, Unmute, 0);  push(b + 48, Unmute, 0);
    push(b + 49, Run, 0);     push(b + 53, Run, 0);     push(b + 56, Run, 0);
    while (cyc < b + 57) begin
      restart  = (cyc == b - 1);
      i2c_done = (cyc == b + 10) || (cyc == b + 40) || (cyc == b + 52) || (cyc == b + 54);
      i2c_err  = (cyc == b + 54);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL boundary cyc=%0d got=%b exp=%b", e.cyc - b, obs, e.val);
        end
      end
    end
    restart = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL boundary pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    int   b, c;
    exp_t e;
    b = cyc + 1;
    push(b + 31, Unmute, 0);
    while (cyc < b + 34) begin
      restart  = (cyc == b - 1);
      i2c_done = (cyc == b + 30);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL async_reset cyc=%0d got=%b exp=%b", e.cyc - b, obs, e.val);
        end
      end
    end
    restart = 1'b0; i2c_done = 1'b0;
    // Assert reset between clock edges; outputs must clear with no edge.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_out(Hold, 2'd0)) begin
      errors++;
      $display("FAIL async_reset_immediate got=%b exp=%b", obs, exp_out(Hold, 2'd0));
    end
    tick();
    tick();
    checks++;
    if (obs !== exp_out(Hold, 2'd0)) begin
      errors++;
      $display("FAIL async_reset_held got=%b exp=%b", obs, exp_out(Hold, 2'd0));
    end
    rst_n = 1'b1;
    c = cyc;
    push(c + 7, Hold, 0); push(c + 8, Settle, 0);
    while (cyc < c + 9) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL async_reset_rerun cyc=%0d got=%b exp=%b", e.cyc - c, obs, e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL async_reset pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_i2c_retry();
    test_timeout();
    test_restart();
    test_boundary();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
